// File: rtl/gaussian_frame_scheduler_if.sv
// Frame-buffer / filter bus for gaussian_frame_scheduler: source RAM read port,
// filter stream in/out and destination RAM write port.
interface gaussian_frame_scheduler_if #(
  parameter int ADDR_W = 14
);
  logic              src_rd_en;
  logic [ADDR_W-1:0] src_rd_addr;
  logic [7:0]        src_rd_data;
  logic              filt_frame_start;
  logic [7:0]        filt_pixel_in;
  logic              filt_valid_in;
  logic [7:0]        filt_pixel_out;
  logic              filt_valid_out;
  logic              dst_wr_en;
  logic [ADDR_W-1:0] dst_wr_addr;
  logic [7:0]        dst_wr_data;

  modport master (
    output src_rd_en, src_rd_addr,
    input  src_rd_data,
    output filt_frame_start, filt_pixel_in, filt_valid_in,
    input  filt_pixel_out, filt_valid_out,
    output dst_wr_en, dst_wr_addr, dst_wr_data
  );

  modport slave (
    input  src_rd_en, src_rd_addr,
    output src_rd_data,
    input  filt_frame_start, filt_pixel_in, filt_valid_in,
    output filt_pixel_out, filt_valid_out,
    input  dst_wr_en, dst_wr_addr, dst_wr_data
  );
endinterface

// File: rtl/gaussian_frame_scheduler.sv
// Sequences one frame pass: source RAM -> 3x3 Gaussian filter -> destination RAM.
// Optional GAUSS_SCHED_PERF_EN adds o_perf_busy_cycles (saturating busy-cycle count).
module gaussian_frame_scheduler #(
  parameter int IMG_WIDTH  = 112,
  parameter int IMG_HEIGHT = 112,
  parameter int ADDR_W     = 14,
  parameter int DRAIN_MAX  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_hold,
  output logic o_busy,
  output logic o_done,
  output logic o_err,
`ifdef GAUSS_SCHED_PERF_EN
  output logic [31:0] o_perf_busy_cycles,
`endif
  gaussian_frame_scheduler_if.master io_bus
);

  localparam int                NPIX       = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] OUT_TOTAL  = ADDR_W'(IMG_WIDTH * (IMG_HEIGHT - 2));
  localparam int                DW         = $clog2(DRAIN_MAX + 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_MAX - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SOF   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [DW-1:0]     r_drain_cnt;
  logic              r_err;
  logic              r_valid;

  logic w_active;
  logic w_accept;
  logic w_rd_en;
  logic w_full;
  logic w_capture;
  logic w_wr_en;
  logic w_overrun;

  always_comb begin
    w_active  = (r_state == S_READ) || (r_state == S_DRAIN);
    w_accept  = (r_state == S_IDLE) && i_start && !i_abort;
    w_rd_en   = (r_state == S_READ) && !i_hold && !i_abort;
    w_full    = (r_wr_cnt == OUT_TOTAL);
    // abort drops any filter output arriving in the same cycle
    w_capture = w_active && io_bus.filt_valid_out && !i_abort;
    w_wr_en   = w_capture && !w_full;
    w_overrun = w_capture && w_full;
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);
  assign o_err  = r_err;

  assign io_bus.src_rd_en        = w_rd_en;
  assign io_bus.src_rd_addr      = w_rd_en ? r_rd_addr : '0;
  assign io_bus.filt_frame_start = (r_state == S_SOF);
  // RAM output is already registered; r_valid aligns the strobe with it
  assign io_bus.filt_valid_in    = r_valid;
  assign io_bus.filt_pixel_in    = r_valid ? io_bus.src_rd_data : '0;
  assign io_bus.dst_wr_en        = w_wr_en;
  assign io_bus.dst_wr_addr      = w_wr_en ? r_wr_cnt : '0;
  assign io_bus.dst_wr_data      = w_wr_en ? io_bus.filt_pixel_out : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rd_addr   <= '0;
      r_wr_cnt    <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= w_rd_en;
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_overrun) r_err <= 1'b1;

      if (i_abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_state     <= S_SOF;
              r_err       <= 1'b0;
              r_rd_addr   <= '0;
              r_wr_cnt    <= '0;
              r_drain_cnt <= '0;
            end
          end
          S_SOF: r_state <= S_READ;
          S_READ: begin
            if (w_rd_en) begin
              if (r_rd_addr == LAST_ADDR) r_state <= S_DRAIN;
              else                        r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
          S_DRAIN: begin
            if (w_full) begin
              r_state <= S_DONE;
            end else if (r_drain_cnt == DRAIN_LAST) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_drain_cnt <= r_drain_cnt + 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef GAUSS_SCHED_PERF_EN
  logic [31:0] r_perf_busy_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_busy_cycles <= '0;
    end else if (w_accept) begin
      r_perf_busy_cycles <= '0;
    end else if (o_busy && (r_perf_busy_cycles != '1)) begin
      r_perf_busy_cycles <= r_perf_busy_cycles + 1'b1;
    end
  end

  assign o_perf_busy_cycles = r_perf_busy_cycles;
`endif

endmodule

// File: tb/tb_gaussian_frame_scheduler.sv
// Self-checking bench for gaussian_frame_scheduler with a behavioural source RAM
// and a 2-cycle-latency filter stand-in (vertical 1-2-1 kernel, W*(H-2) outputs).
module tb_gaussian_frame_scheduler;
  localparam int W    = 8;
  localparam int H    = 4;
  localparam int AW   = 5;
  localparam int DMAX = 8;
  localparam int NPIX = W * H;
  localparam int NOUT = W * (H - 2);

  logic clk = 1'b0;
  logic rst, start, abort, hold;
  logic busy, done, err;
`ifdef GAUSS_SCHED_PERF_EN
  logic [31:0] perf;
`endif

  gaussian_frame_scheduler_if #(.ADDR_W(AW)) bus ();

  gaussian_frame_scheduler #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (AW),
    .DRAIN_MAX (DMAX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_start(start),
    .i_abort(abort),
    .i_hold (hold),
    .o_busy (busy),
    .o_done (done),
    .o_err  (err),
`ifdef GAUSS_SCHED_PERF_EN
    .o_perf_busy_cycles(perf),
`endif
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Source RAM, 1-cycle read latency
  logic [7:0] img [NPIX];
  always @(posedge clk) if (bus.src_rd_en) bus.src_rd_data <= img[bus.src_rd_addr];

  // Filter stand-in: f_over emits from row 1 (extra outputs), f_mute emits nothing
  logic [7:0] fpix [NPIX];
  int         fcnt = 0;
  logic       s1v = 1'b0, s2v = 1'b0;
  logic [7:0] s1d = '0, s2d = '0;
  logic       f_mute = 1'b0, f_over = 1'b0;

  function automatic logic [7:0] filt_val(input int n, input logic [7:0] p);
    if (n < 2 * W) return p;
    return 8'((int'(fpix[n-2*W]) + 2 * int'(fpix[n-W]) + int'(p)) >> 2);
  endfunction

  always @(posedge clk) begin
    if (bus.filt_frame_start) begin
      fcnt <= 0;
      s1v  <= 1'b0;
      s2v  <= 1'b0;
    end else begin
      s2v <= s1v;
      s2d <= s1d;
      s1v <= 1'b0;
      if (bus.filt_valid_in && fcnt < NPIX) begin
        fpix[fcnt] <= bus.filt_pixel_in;
        if (!f_mute && fcnt >= (f_over ? W : 2 * W)) begin
          s1v <= 1'b1;
          s1d <= filt_val(fcnt, bus.filt_pixel_in);
        end
        fcnt <= fcnt + 1;
      end
    end
  end
  assign bus.filt_valid_out = s2v;
  assign bus.filt_pixel_out = s2d;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int kind;      // 0: flat 100, 1: ramp, 2: random
    int hold_at;
    int hold_len;
    int start_at;  // address at which a stray start is pulsed, -1 none
    bit mute;
    bit over;
    int exp_wr;
    int exp_busy;
    bit exp_err;
  } vec_t;
  vec_t tbl[8];

  int n_checks = 0;
  int n_fail   = 0;
  int m_rd, m_rd_next, m_seq_err, m_hold_viol, m_busy, m_done, m_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return {31'b0, busy, done, err, bus.src_rd_en, bus.src_rd_addr, bus.filt_frame_start,
            bus.filt_pixel_in, bus.filt_valid_in, bus.dst_wr_en, bus.dst_wr_addr,
            bus.dst_wr_data};
  endfunction

  function automatic logic [7:0] exp_val(input int k);
    int n;
    n = k + (f_over ? W : 2 * W);
    if (n < 2 * W) return img[n];
    return 8'((int'(img[n-2*W]) + 2 * int'(img[n-W]) + int'(img[n])) >> 2);
  endfunction

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.src_rd_en) begin
        if (int'(bus.src_rd_addr) != m_rd_next) m_seq_err++;
        if (hold) m_hold_viol++;
        m_rd_next = int'(bus.src_rd_addr) + 1;
        m_rd++;
      end
      if (busy) m_busy++;
      if (done) m_done++;
      if (bus.dst_wr_en) begin
        m_wr++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(bus.dst_wr_addr), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.dst_wr_addr), 64'(e.addr));
          check("wr_data", 64'(bus.dst_wr_data), 64'(e.data));
        end
      end
    end
  endtask

  task automatic begin_pass(input vec_t r);
    for (int i = 0; i < NPIX; i++)
      case (r.kind)
        0:       img[i] = 8'd100;
        1:       img[i] = 8'(i * 7 + 3);
        default: img[i] = 8'($urandom_range(0, 255));
      endcase
    f_mute = r.mute;
    f_over = r.over;
    exp_q.delete();
    if (!r.mute)
      for (int k = 0; k < NOUT; k++) exp_q.push_back({AW'(k), exp_val(k)});
    m_rd = 0; m_rd_next = 0; m_seq_err = 0; m_hold_viol = 0;
    m_busy = 0; m_done = 0; m_wr = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_pass(input vec_t r);
    bit got_done = 0;
    bit held     = 0;
    int hold_left = 0;
    begin_pass(r);
    for (int c = 0; c < 300 && !got_done; c++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1;
      end else begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) hold = 1'b0;
        end else if (!held && r.hold_len > 0 && bus.src_rd_en &&
                     int'(bus.src_rd_addr) == r.hold_at) begin
          hold = 1'b1;
          hold_left = r.hold_len;
          held = 1;
        end
        if (start) start = 1'b0;
        else if (r.start_at >= 0 && bus.src_rd_en && int'(bus.src_rd_addr) == r.start_at)
          start = 1'b1;
      end
    end
    check("done_seen", 64'(got_done), 64'd1);
    if (!got_done) begin
      hold = 1'b0; start = 1'b0; abort = 1'b1;
      @(negedge clk) abort = 1'b0;
    end
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    check("done_count", 64'(m_done), 64'd1);
    check("wr_count", 64'(m_wr), 64'(r.exp_wr));
    check("rd_count", 64'(m_rd), 64'(NPIX));
    check("rd_contiguous", 64'(m_seq_err), 64'd0);
    check("rd_during_hold", 64'(m_hold_viol), 64'd0);
    check("busy_cycles", 64'(m_busy), 64'(r.exp_busy));
    check("err", 64'(err), 64'(r.exp_err));
    check("sb_left", 64'(exp_q.size()), 64'd0);
`ifdef GAUSS_SCHED_PERF_EN
    check("perf_busy_cycles", 64'(perf), 64'(m_busy));
`endif
  endtask

  task automatic wait_rd_addr(input int a, output bit found);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (bus.src_rd_en && int'(bus.src_rd_addr) == a) found = 1;
    end
  endtask

  initial begin
    bit found;
    int bsum;
    int w0, d0;
    //       kind hold_at len start_at mute over wr  busy err
    tbl[0] = '{0,  -1,  0,  -1,  0, 0, 16, 38, 0};
    tbl[1] = '{1,  -1,  0,  -1,  0, 0, 16, 38, 0};
    tbl[2] = '{1,  10,  5,  -1,  0, 0, 16, 43, 0};
    tbl[3] = '{2,  31,  3,  -1,  0, 0, 16, 41, 0};
    tbl[4] = '{1,  -1,  0,  12,  0, 0, 16, 38, 0};
    tbl[5] = '{2,  -1,  0,  -1,  1, 0,  0, 42, 1};
    tbl[6] = '{1,  -1,  0,  -1,  0, 0, 16, 38, 0};
    tbl[7] = '{2,  -1,  0,  -1,  0, 1, 16, 35, 1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
    m_rd = 0; m_rd_next = 0; m_seq_err = 0; m_hold_viol = 0;
    m_busy = 0; m_done = 0; m_wr = 0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
`ifdef GAUSS_SCHED_PERF_EN
    check("reset_perf", 64'(perf), 64'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_pass(tbl[i]);

    // abort mid-READ, then a clean pass
    begin_pass(tbl[1]);
    wait_rd_addr(20, found);
    check("abort_reach_addr", 64'(found), 64'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk) abort = 1'b0;
    exp_q.delete();
    w0 = m_wr;
    d0 = m_done;
    repeat (20) @(negedge clk);
    check("abort_no_write", 64'(m_wr), 64'(w0));
    check("abort_no_done", 64'(m_done), 64'(d0));
    run_pass(tbl[6]);

    // start and abort together in IDLE
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    check("start_abort_busy", 64'(busy), 64'd0);
    bsum = 0;
    repeat (3) begin
      @(negedge clk);
      bsum += int'(busy);
    end
    check("start_abort_idle", 64'(bsum), 64'd0);

    // rst mid-READ after an overrun has already raised err
    begin_pass(tbl[7]);
    wait_rd_addr(28, found);
    check("rst_reach_addr", 64'(found), 64'd1);
    check("overrun_err_mid_pass", 64'(err), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_outputs", outs(), 64'd0);
    @(negedge clk) rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("rst_idle", 64'(busy), 64'd0);
    run_pass(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
